// File: rtl/freq_meas.sv
// freq_meas: measures the period and high time, in clk cycles, of a slow asynchronous input.
// The input passes through a two-flop synchroniser plus one delay flop for edge detection.
// A one-shot (CONT=0) or free-running (CONT=1) FSM counts clk cycles between synchronised
// edges. A saturating counter turns a stuck input into a sticky timeout.

module freq_meas #(
    parameter int unsigned W    = 16,
    parameter bit          CONT = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_sig_in,
    input  logic         i_start,
    output logic         o_busy,
    output logic         o_valid,
    output logic         o_timeout,
    output logic [W-1:0] o_period,
    output logic [W-1:0] o_high_time
);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StSync,
        StHigh,
        StLow
    } state_e;

    localparam logic [W-1:0] CntMax = {W{1'b1}};
    localparam logic [W-1:0] CntOne = W'(1);

    // Synchroniser and edge-detect flops
    logic r_s1;
    logic r_s2;
    logic r_s3;

    // FSM state, counter and registered outputs
    state_e       r_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_hi_cap;
    logic [W-1:0] r_period;
    logic [W-1:0] r_high_time;
    logic         r_busy;
    logic         r_valid;
    logic         r_timeout;

    // Combinational helpers
    logic         w_rise;
    logic         w_fall;
    logic         w_sat;
    logic         w_exit;
    logic         w_expire;
    logic [W-1:0] w_cnt_inc;

    // Two-flop synchroniser (s1, s2) and one extra stage (s3) for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Edge detect, saturating increment and the per-state "exiting edge" used by the timeout
    always_comb begin
        w_rise    = r_s2 & ~r_s3;
        w_fall    = ~r_s2 & r_s3;
        w_sat     = (r_cnt == CntMax);
        // Held at the ceiling so a fall at saturation cannot wrap the LOW count back to zero
        w_cnt_inc = w_sat ? r_cnt : r_cnt + CntOne;
        w_exit    = 1'b0;
        case (r_state)
            StArm:   w_exit = ~r_s2;
            StSync:  w_exit = w_rise;
            StHigh:  w_exit = w_fall;
            StLow:   w_exit = w_rise;
            default: w_exit = 1'b0;
        endcase
        // The exiting edge wins over saturation in the same cycle
        w_expire  = w_sat & ~w_exit;
    end

    // Measurement FSM; all outputs registered here
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_hi_cap    <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == StIdle) begin
                if (i_start) begin
                    r_state   <= StArm;
                    r_busy    <= 1'b1;
                    r_timeout <= 1'b0;
                    r_cnt     <= '0;
                end
            end else if (w_expire) begin
                // Stuck input: abandon the measurement, keep the last published results
                r_state   <= StIdle;
                r_busy    <= 1'b0;
                r_timeout <= 1'b1;
                r_cnt     <= '0;
            end else begin
                case (r_state)
                    StArm: begin
                        // Wait for a low level so a partial first high phase is never measured
                        if (w_exit) begin
                            r_state <= StSync;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    StSync: begin
                        if (w_exit) begin
                            r_state <= StHigh;
                            r_cnt   <= CntOne;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    StHigh: begin
                        r_cnt <= w_cnt_inc;
                        if (w_exit) begin
                            r_hi_cap <= r_cnt;
                            r_state  <= StLow;
                        end
                    end
                    StLow: begin
                        if (w_exit) begin
                            r_period    <= r_cnt;
                            r_high_time <= r_hi_cap;
                            r_valid     <= 1'b1;
                            if (CONT) begin
                                r_state <= StHigh;
                                r_cnt   <= CntOne;
                            end else begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_valid     = r_valid;
    assign o_timeout   = r_timeout;
    assign o_period    = r_period;
    assign o_high_time = r_high_time;

endmodule

// File: tb/tb_freq_meas.sv
// tb_freq_meas: drives directed and random waveforms into three freq_meas instances
// (W=8 one-shot, W=8 continuous, W=2 one-shot) sharing one input, and compares every valid
// pulse against a reference model that scans the driven waveform for edges.

module tb_freq_meas;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sig;
    logic       start_a;
    logic       start_c;
    logic       start_n;
    logic       busy_a, valid_a, to_a;
    logic       busy_c, valid_c, to_c;
    logic       busy_n, valid_n, to_n;
    logic [7:0] per_a, hi_a, per_c, hi_c;
    logic [1:0] per_n, hi_n;

    freq_meas #(.W(8), .CONT(1'b0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_sig_in(sig), .i_start(start_a),
        .o_busy(busy_a), .o_valid(valid_a), .o_timeout(to_a),
        .o_period(per_a), .o_high_time(hi_a)
    );

    freq_meas #(.W(8), .CONT(1'b1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_sig_in(sig), .i_start(start_c),
        .o_busy(busy_c), .o_valid(valid_c), .o_timeout(to_c),
        .o_period(per_c), .o_high_time(hi_c)
    );

    freq_meas #(.W(2), .CONT(1'b0)) u_n (
        .i_clk(clk), .i_rst_n(rst_n), .i_sig_in(sig), .i_start(start_n),
        .o_busy(busy_n), .o_valid(valid_n), .o_timeout(to_n),
        .o_period(per_n), .o_high_time(hi_n)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   hist[$];
    bit   pat[$];
    int   kicks[$];
    int   got_id[$], got_p[$], got_h[$], got_t[$];
    int   exp_p[$], exp_h[$];
    bit   exp_to;
    logic [2:0] busy_prev = '0;
    int   after_pend = -1;
    logic busy_before = 1'b0;
    logic busy_after  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse with its instance, values and cycle, plus busy around it
    always @(negedge clk) begin : mon
        logic [2:0] v;
        logic [2:0] b;
        v = {valid_n, valid_c, valid_a};
        b = {busy_n, busy_c, busy_a};
        if (after_pend >= 0) begin
            busy_after = b[after_pend];
            after_pend = -1;
        end
        for (int i = 0; i < 3; i++) begin
            if (v[i]) begin
                got_id.push_back(i);
                got_t.push_back(cyc);
                got_p.push_back(i == 0 ? int'(per_a) : i == 1 ? int'(per_c) : int'(per_n));
                got_h.push_back(i == 0 ? int'(hi_a) : i == 1 ? int'(hi_c) : int'(hi_n));
                busy_before = busy_prev[i];
                after_pend  = i;
            end
        end
        busy_prev = b;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int to_of(input int w);
        return (w == 0) ? int'(to_a) : (w == 1) ? int'(to_c) : int'(to_n);
    endfunction

    // One clk cycle of input level v; st selects which instance gets a start pulse (-1: none)
    task automatic tick(input bit v, input int st);
        @(negedge clk);
        sig     = v;
        start_a = (st == 0);
        start_c = (st == 1);
        start_n = (st == 2);
        hist.push_back(v);
    endtask

    task automatic add_phase(input bit v, input int n);
        for (int i = 0; i < n; i++) pat.push_back(v);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference: from the start cycle, wait until the input is low, then every pair of
    // consecutive rising edges is one result (period = rise-to-rise, high = rise-to-fall).
    // A period longer than the counter ceiling is a timeout instead of a result.
    task automatic run_model(input int ts, input int maxm, input int cap);
        int k, r, f, r2, sz;
        exp_p.delete();
        exp_h.delete();
        exp_to = 1'b0;
        sz = hist.size();
        k = ts;
        while (k < sz && hist[k]) k++;
        r = k + 1;
        while (r < sz && !hist[r]) r++;
        if (r >= sz) return;
        while (exp_p.size() < maxm) begin
            f = r + 1;
            while (f < sz && hist[f]) f++;
            r2 = f + 1;
            while (r2 < sz && !hist[r2]) r2++;
            if (r2 >= sz) return;
            if (r2 - r > cap) begin
                exp_to = 1'b1;
                return;
            end
            exp_p.push_back(r2 - r);
            exp_h.push_back(f - r);
            r = r2;
        end
    endtask

    // Start is issued mid-way through three cycles of level pre, then pat plays, then a
    // quiet tail at the final level lets the last edges through the synchroniser.
    task automatic run_case(input string tag, input int which, input bit pre, input int cap,
                            input int maxm);
        int ts, mine, n, st;
        bit last;
        hist.delete();
        got_id.delete(); got_p.delete(); got_h.delete(); got_t.delete();
        tick(pre, -1);
        tick(pre, which);
        ts = hist.size() - 1;
        tick(pre, -1);
        foreach (pat[i]) begin
            st = -1;
            foreach (kicks[j]) if (kicks[j] == i) st = which;
            tick(pat[i], st);
        end
        last = (pat.size() > 0) ? pat[pat.size() - 1] : pre;
        for (int i = 0; i < 8; i++) tick(last, -1);
        run_model(ts, maxm, cap);
        mine = 0;
        foreach (got_id[i]) if (got_id[i] == which) mine++;
        check({tag, " valid count"}, mine, exp_p.size());
        check({tag, " stray valid"}, got_id.size() - mine, 0);
        n = 0;
        foreach (got_id[i]) begin
            if (got_id[i] == which && n < exp_p.size()) begin
                check({tag, " period"}, got_p[i], exp_p[n]);
                check({tag, " high_time"}, got_h[i], exp_h[n]);
                n++;
            end
        end
        check({tag, " timeout"}, to_of(which), int'(exp_to));
    endtask

    initial begin
        int n;
        bit pre;
        rst_n   = 1'b0;
        sig     = 1'b0;
        start_a = 1'b0;
        start_c = 1'b0;
        start_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy_a, 0);
        check("reset valid", valid_a, 0);
        check("reset timeout", to_a, 0);
        check("reset period", per_a, 0);
        check("reset high_time", hi_a, 0);
        check("reset busy cont", busy_c, 0);
        rst_n = 1'b1;

        // div2: one high, one low
        pat.delete(); kicks.delete();
        for (int i = 0; i < 4; i++) begin add_phase(1, 1); add_phase(0, 1); end
        run_case("div2", 0, 0, 255, 1);
        check("div2 period out", per_a, 2);
        check("div2 high out", hi_a, 1);
        check("div2 busy before valid", busy_before, 1);
        check("div2 busy after valid", busy_after, 0);

        // Stuck high: timeout, no valid, prior results kept
        hist.delete(); got_id.delete(); got_p.delete(); got_h.delete(); got_t.delete();
        repeat (3) tick(1, -1);
        tick(1, 0);
        n = 0;
        while (!to_a && n < 300) begin
            tick(1, -1);
            n++;
        end
        check("stuck timeout", to_a, 1);
        check("stuck latency in 255..258", int'(n >= 255 && n <= 258), 1);
        check("stuck no valid", got_id.size(), 0);
        check("stuck period held", per_a, 2);
        check("stuck high held", hi_a, 1);
        check("stuck busy", busy_a, 0);

        // div6 with input already high at start; start also clears the timeout
        pat.delete(); kicks.delete();
        for (int i = 0; i < 3; i++) begin add_phase(1, 3); add_phase(0, 3); end
        run_case("div6 start-high", 0, 1, 255, 1);
        check("div6 period out", per_a, 6);
        check("div6 high out", hi_a, 3);

        // div4 with extra starts while busy: ignored
        pat.delete(); kicks.delete();
        for (int i = 0; i < 4; i++) begin add_phase(1, 2); add_phase(0, 2); end
        kicks.push_back(1); kicks.push_back(2); kicks.push_back(5);
        run_case("div4 kicked", 0, 0, 255, 1);
        check("div4 period out", per_a, 4);
        kicks.delete();

        // Reset in the middle of a high phase
        hist.delete(); got_id.delete(); got_p.delete(); got_h.delete(); got_t.delete();
        tick(0, -1); tick(0, 0); tick(0, -1);
        repeat (6) tick(1, -1);
        check("mid busy", busy_a, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-reset busy", busy_a, 0);
        check("mid-reset period", per_a, 0);
        check("mid-reset high", hi_a, 0);
        check("mid-reset timeout", to_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid-reset no publish", got_id.size(), 0);
        pat.delete();
        for (int i = 0; i < 3; i++) begin add_phase(1, 3); add_phase(0, 2); end
        run_case("div5 after reset", 0, 0, 255, 1);
        check("div5 period out", per_a, 5);

        // div3 continuous: a result every 3 cycles
        pat.delete();
        for (int i = 0; i < 6; i++) begin add_phase(1, 2); add_phase(0, 1); end
        run_case("div3 cont", 1, 0, 255, 1000);
        check("div3 count", got_id.size(), 5);
        for (int i = 1; i < got_t.size(); i++) check("div3 spacing", got_t[i] - got_t[i-1], 3);
        pulse_reset();

        // W=2: rise exactly at counter saturation wins
        pat.delete();
        for (int i = 0; i < 3; i++) begin add_phase(1, 2); add_phase(0, 1); end
        run_case("w2 rise at sat", 2, 0, 3, 1);
        check("w2 period out", per_n, 3);
        check("w2 high out", hi_n, 2);

        // W=2: period 4 overflows the counter
        pat.delete();
        for (int i = 0; i < 2; i++) begin add_phase(1, 2); add_phase(0, 2); end
        run_case("w2 overflow", 2, 0, 3, 1);
        check("w2 overflow period held", per_n, 3);

        // Random one-shot measurements
        for (int it = 0; it < 6; it++) begin
            pat.delete();
            pre = 1'($urandom_range(0, 1));
            for (int j = 0; j < 3; j++) begin
                add_phase(1, $urandom_range(1, 12));
                add_phase(0, $urandom_range(1, 12));
            end
            run_case("rand oneshot", 0, pre, 255, 1);
        end

        // Random continuous streams
        for (int it = 0; it < 3; it++) begin
            pat.delete();
            pre = 1'($urandom_range(0, 1));
            for (int j = 0; j < 5; j++) begin
                add_phase(1, $urandom_range(1, 9));
                add_phase(0, $urandom_range(1, 9));
            end
            run_case("rand cont", 1, pre, 255, 1000);
            pulse_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
